// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Byte FIFO between the CPU store path and the ft232if UART
//                transmitter. Buffers stored bytes and drains them with a
//                one-cycle send_flag strobe, spaced by a hold interval.
//                Exposes fill level and a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  input  logic              send_available,
  output logic              send_flag,
  output logic [7:0]        send_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  // Hold counter must be able to hold HOLD_CYCLES-1
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              push;
  logic              pop;
  logic              drop;

  // Status flags decode directly from the occupancy register
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // full is the pre-edge value, so a same-edge pop never rescues a push
  assign push = we & ~full;
  assign drop = we &  full;
  assign pop  = (state == ST_IDLE) & ~empty & send_available;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; send_available only matters in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pop) state_nxt = ST_SEND;
      ST_SEND: state_nxt = ST_HOLD;
      ST_HOLD: if (hold_cnt == '0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: strobe is decoded from state so reset drops it at once
  always_comb begin
    send_flag = (state == ST_SEND);
  end

  // Hold interval counter, loaded on leaving SEND
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == ST_SEND) begin
      hold_cnt <= HOLD_INIT;
    end else if (state == ST_HOLD && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HOLD_ONE;
    end
  end

  // Storage array; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and output byte register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      send_data <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        send_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a dropped push outranks a same-edge clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. Bytes accepted by the
//                FIFO go into a scoreboard queue; every send_flag pulse pops
//                and compares the oldest entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int HOLD_CYCLES = 2;
  localparam int SPACING     = 1 + HOLD_CYCLES + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              we = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              clr_ovf = 1'b0;
  logic              send_available = 1'b0;
  logic              send_flag;
  logic [7:0]        send_data;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses = 0;
  bit prev_flag = 1'b0;
  logic [7:0] sb [$];
  int pulse_cyc [$];

  uart_tx_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .we            (we),
    .wr_data       (wr_data),
    .clr_ovf       (clr_ovf),
    .send_available(send_available),
    .send_flag     (send_flag),
    .send_data     (send_data),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Rising-edge index
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every strobe must be one cycle wide and carry the oldest queued byte
  always @(negedge clk) begin
    logic [7:0] exp;
    if (rst_n && send_flag) begin
      pulses++;
      pulse_cyc.push_back(cyc);
      checks++;
      if (prev_flag) begin
        errors++;
        $display("FAIL pulse_width: send_flag high on consecutive cycles at edge %0d, required one cycle", cyc);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_send: got send_data=%02h, required no pulse (scoreboard empty)", send_data);
      end else begin
        exp = sb.pop_front();
        if (send_data !== exp) begin
          errors++;
          $display("FAIL send_data: got %02h, required %02h", send_data, exp);
        end
      end
    end
    prev_flag = rst_n && send_flag;
  end

  // Global time limit
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Push one byte (entered and left at posedge+1); enq says whether the FIFO should accept it
  task automatic push(input logic [7:0] b, input bit enq);
    we = 1'b1;
    wr_data = b;
    if (enq) sb.push_back(b);
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // Wait until all expected bytes have left, then let the hold interval expire
  task automatic wait_drain(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && count == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes still expected, count=%0d, required 0 within %0d cycles",
               sb.size(), count, bound);
    end
    repeat (SPACING) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int e_cyc;
    int p0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({send_flag, send_data, count, empty, full, overflow} !== {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: flag=%b data=%02h count=%0d empty=%b full=%b ovf=%b, required 0/00/0/1/0/0",
               send_flag, send_data, count, empty, full, overflow);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_available = 1'b1;
    pulse_cyc.delete();
    p0 = pulses;
    push(8'h41, 1'b1);
    e_cyc = cyc;
    wait_drain(40);
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL first_pulse_count: got %0d pulses, required 1", pulses - p0);
    end
    checks++;
    if (pulse_cyc.size() < 1 || pulse_cyc[0] != e_cyc + 1) begin
      errors++;
      $display("FAIL first_latency: pulse at edge %0d, required %0d",
               (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1, e_cyc + 1);
    end
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL first_count: count=%0d empty=%b, required 0/1", count, empty);
    end
  endtask

  task automatic test_ordering();
    int p0;
    send_available = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
    @(negedge clk);
    checks++;
    if (count !== 5'd5) begin
      errors++;
      $display("FAIL order_count: got %0d, required 5", count);
    end
    @(posedge clk);
    #1;
    pulse_cyc.delete();
    p0 = pulses;
    send_available = 1'b1;
    wait_drain(100);
    checks++;
    if (pulses - p0 != 5) begin
      errors++;
      $display("FAIL order_pulses: got %0d, required 5", pulses - p0);
    end
    for (int i = 1; i < pulse_cyc.size(); i++) begin
      checks++;
      if (pulse_cyc[i] - pulse_cyc[i-1] != SPACING) begin
        errors++;
        $display("FAIL order_spacing: gap %0d, required %0d", pulse_cyc[i] - pulse_cyc[i-1], SPACING);
      end
    end
  endtask

  task automatic test_full_overflow();
    send_available = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(8'(8'h80 + i), i < DEPTH);
    @(negedge clk);
    checks++;
    if (full !== 1'b1 || count !== 5'(DEPTH) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_state: full=%b count=%0d ovf=%b, required 1/%0d/1", full, count, overflow, DEPTH);
    end
    @(posedge clk);
    #1;
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || count !== 5'(DEPTH)) begin
      errors++;
      $display("FAIL clr_ovf: ovf=%b count=%0d, required 0/%0d", overflow, count, DEPTH);
    end
    @(posedge clk);
    #1;
  endtask

  // Expects the FIFO to be full and held off on entry
  task automatic test_simultaneous();
    we = 1'b1;
    wr_data = 8'hEE;
    send_available = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 5'(DEPTH - 1) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL sim_full: count=%0d ovf=%b, required %0d/1", count, overflow, DEPTH - 1);
    end
    @(posedge clk);
    #1;
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    wait_drain(200);
    send_available = 1'b0;
    push(8'h55, 1'b1);
    we = 1'b1;
    wr_data = 8'h66;
    sb.push_back(8'h66);
    send_available = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 5'd1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sim_one: count=%0d ovf=%b, required 1/0", count, overflow);
    end
    wait_drain(60);
  endtask

  task automatic test_wrap();
    send_available = 1'b1;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 3; i++) push(8'(8'h10 + r * 3 + i), 1'b1);
      wait_drain(60);
    end
    checks++;
    if (count !== 5'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: count=%0d ovf=%b, required 0/0", count, overflow);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int p0;
    send_available = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i), 1'b1);
    send_available = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (send_flag) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_send_timeout: send_flag=0, required a pulse within 20 cycles");
    end
    checks++;
    if (count !== 5'd4) begin
      errors++;
      $display("FAIL mid_queued: count=%0d, required 4", count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (send_flag !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: flag=%b count=%0d empty=%b, required 0/0/1", send_flag, count, empty);
    end
    sb.delete();
    p0 = pulses;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (pulses != p0 || count !== 5'd0) begin
      errors++;
      $display("FAIL mid_after: %0d pulses count=%0d, required 0 pulses count=0", pulses - p0, count);
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_full_overflow();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
